// File: rtl/input_controller.sv
// NES-style serial gamepad reader: generates latch/shift-clock pulses and captures 8 active-low buttons per frame.
// Optional macro INPUT_CTRL_EDGE_EN turns button_data_out_tb into one-cycle press events.
`timescale 1ns/1ps

module input_controller #(
    parameter int unsigned HALF_PERIOD  = 300,
    parameter int unsigned FRAME_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_data_in,
    output logic       latch_tb,
    output logic       pulse_tb,
    output logic       slow_clk_tb,
    output logic [3:0] button_data_out_tb,
    output logic [7:0] buttons,
    output logic       data_valid
);

    localparam int unsigned DIV_W   = $clog2(HALF_PERIOD);
    localparam int unsigned FRAME_W = $clog2(FRAME_CYCLES);
    localparam int unsigned STEP_W  = 5;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(HALF_PERIOD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_LATCH_OFF = STEP_W'(2);
    localparam logic [STEP_W-1:0]  STEP_SAMPLE_A  = STEP_W'(3);
    localparam logic [STEP_W-1:0]  STEP_LAST      = STEP_W'(19);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_sync;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_slow_clk;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic                r_pending;
    logic [STEP_W-1:0]   r_step;
    logic [7:0]          r_shift;
    logic                r_latch;
    logic                r_pulse;
    logic [3:0]          r_out;
    logic [7:0]          r_buttons;
    logic                r_data_valid;

    logic                w_tick;
    logic                w_rise;
    logic                w_frame_end;
    logic                w_sample;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [2:0]          w_bit_idx;
    logic [3:0]          w_game_new;
    logic [3:0]          w_game_old;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_rise      = w_tick && !r_slow_clk;
    assign w_frame_end = (r_frame_cnt == FRAME_LAST);
    assign w_sample    = ~r_sync[1];
    assign w_step_nxt  = r_step + STEP_W'(1);
    assign w_bit_idx   = 3'((w_step_nxt - STEP_SAMPLE_A) >> 1);
    assign w_game_new  = {r_shift[0], r_shift[5], r_shift[6], r_shift[7]};
    assign w_game_old  = {r_buttons[0], r_buttons[5], r_buttons[6], r_buttons[7]};

    // Two-flop synchronizer; idles at the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], button_data_in};
        end
    end

    // Slow-clock divider; each terminal count is one tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_slow_clk <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_slow_clk <= ~r_slow_clk;
        end else begin
            r_div_cnt  <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    // Read sequencer: step index advances one per tick from latch rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_step       <= '0;
            r_shift      <= '0;
            r_latch      <= 1'b0;
            r_pulse      <= 1'b0;
            r_out        <= '0;
            r_buttons    <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_frame_end && r_state == S_IDLE) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise && r_pending) begin
                        r_state   <= S_LATCH;
                        r_pending <= 1'b0;
                        r_step    <= '0;
                        r_latch   <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (w_tick) begin
                        r_step <= w_step_nxt;
                        if (w_step_nxt == STEP_LATCH_OFF) begin
                            r_latch <= 1'b0;
                        end
                        if (w_step_nxt == STEP_SAMPLE_A) begin
                            r_shift[0] <= w_sample;
                            r_state    <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_step  <= w_step_nxt;
                        r_pulse <= ~w_step_nxt[0];
                        if (w_step_nxt == STEP_LAST) begin
                            r_state      <= S_DONE;
                            r_buttons    <= r_shift;
                            r_data_valid <= 1'b1;
`ifdef INPUT_CTRL_EDGE_EN
                            r_out        <= w_game_new & ~w_game_old;
`else
                            r_out        <= w_game_new;
`endif
                        end else if (w_step_nxt[0]) begin
                            r_shift[w_bit_idx] <= w_sample;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef INPUT_CTRL_EDGE_EN
                    r_out   <= '0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef INPUT_CTRL_EDGE_EN
    // Previous-frame snapshot only matters for press-event mode.
    logic w_unused_old;
    assign w_unused_old = ^w_game_old;
`endif

    assign latch_tb           = r_latch;
    assign pulse_tb           = r_pulse;
    assign slow_clk_tb        = r_slow_clk;
    assign button_data_out_tb = r_out;
    assign buttons            = r_buttons;
    assign data_valid         = r_data_valid;

endmodule

// File: tb/tb_input_controller.sv
// Scoreboard bench for input_controller: models a serial pad, predicts each frame's snapshot and checks strobe timing.
`timescale 1ns/1ps

module tb_input_controller;

    localparam int unsigned HP = 4;
    localparam int unsigned FC = 200;
`ifdef INPUT_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_data_in = 1'b1;
    logic       latch_tb;
    logic       pulse_tb;
    logic       slow_clk_tb;
    logic [3:0] button_data_out_tb;
    logic [7:0] buttons;
    logic       data_valid;

    input_controller #(
        .HALF_PERIOD (HP),
        .FRAME_CYCLES(FC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .button_data_in    (button_data_in),
        .latch_tb          (latch_tb),
        .pulse_tb          (pulse_tb),
        .slow_clk_tb       (slow_clk_tb),
        .button_data_out_tb(button_data_out_tb),
        .buttons           (buttons),
        .data_valid        (data_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] game_bits(input logic [7:0] p);
        return {p[0], p[5], p[6], p[7]};
    endfunction

    // Pad model state and scoreboard
    logic [7:0] pat = 8'h00;
    logic [7:0] model_prev = 8'h00;
    logic [7:0] sb_btn[$];
    logic [3:0] sb_out[$];
    logic [7:0] last_btn;
    logic [3:0] last_out;
    logic [7:0] e_b;
    logic [3:0] e_o;
    logic [3:0] e_lvl;
    bit   have_last = 0;
    bit   first_pending = 1;
    bit   prev_latch = 0;
    bit   prev_pulse = 0;
    bit   dv_prev = 0;
    int   cyc = 0;
    int   latch_start = 0;
    int   pulse_start = 0;
    int   pulse_cnt = 0;
    int   n_frames = 0;
    int   n_overlap = 0;

    always @(negedge clk) begin
        if (reset) begin
            sb_btn.delete();
            sb_out.delete();
            prev_latch     = 0;
            prev_pulse     = 0;
            dv_prev        = 0;
            pulse_cnt      = 0;
            model_prev     = 8'h00;
            first_pending  = 1;
            have_last      = 0;
            cyc            = 0;
            button_data_in = 1'b1;
        end else begin
            cyc++;
            if (latch_tb && pulse_tb) n_overlap++;
            if (latch_tb && !prev_latch) begin
                check("latch_on_slow_rise", 32'(slow_clk_tb), 32'd1);
                if (first_pending) begin
                    check("first_latch_window", 32'(cyc >= 201 && cyc <= 208), 32'd1);
                    first_pending = 0;
                end
                if (have_last) begin
                    check("hold_buttons", 32'(buttons), 32'(last_btn));
                    check("hold_out", 32'(button_data_out_tb), EDGE ? 32'd0 : 32'(last_out));
                end
                e_lvl = game_bits(pat);
                sb_btn.push_back(pat);
                sb_out.push_back(EDGE ? (e_lvl & ~game_bits(model_prev)) : e_lvl);
                model_prev     = pat;
                latch_start    = cyc;
                pulse_cnt      = 0;
                button_data_in = ~pat[0];
            end
            if (!latch_tb && prev_latch) begin
                check("latch_width", 32'(cyc - latch_start), 32'(2 * HP));
            end
            if (pulse_tb && !prev_pulse) begin
                pulse_cnt++;
                pulse_start    = cyc;
                button_data_in = (pulse_cnt < 8) ? ~pat[pulse_cnt[2:0]] : 1'b1;
            end
            if (!pulse_tb && prev_pulse) begin
                check("pulse_width", 32'(cyc - pulse_start), 32'(HP));
            end
            if (data_valid) begin
                if (sb_btn.size() == 0) begin
                    check("dv_unexpected", 32'(data_valid), 32'd0);
                end else begin
                    e_b = sb_btn.pop_front();
                    e_o = sb_out.pop_front();
                    check("buttons", 32'(buttons), 32'(e_b));
                    check("game_out", 32'(button_data_out_tb), 32'(e_o));
                    check("pulse_count", 32'(pulse_cnt), 32'd8);
                    check("frame_len", 32'(cyc - latch_start), 32'(19 * HP));
                    last_btn  = e_b;
                    last_out  = e_o;
                    have_last = 1;
                    n_frames++;
                end
            end else if (dv_prev && have_last) begin
                check("out_after_dv", 32'(button_data_out_tb), EDGE ? 32'd0 : 32'(last_out));
            end
            dv_prev    = data_valid;
            prev_latch = latch_tb;
            prev_pulse = pulse_tb;
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = n_frames + n;
        budget = n * 2 * FC;
        while (n_frames < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (n_frames < target) check("frame_timeout", 32'(n_frames), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_latch"}, 32'(latch_tb), 32'd0);
        check({tag, "_pulse"}, 32'(pulse_tb), 32'd0);
        check({tag, "_out"}, 32'(button_data_out_tb), 32'd0);
        check({tag, "_buttons"}, 32'(buttons), 32'd0);
        check({tag, "_dv"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_slow", 32'(slow_clk_tb), 32'd0);
        reset = 1'b0;

        pat = 8'h00;
        wait_frames(2);
        pat = 8'h81;
        wait_frames(2);
        pat = 8'h60;
        wait_frames(1);

        // Abort a frame during pulse 3
        pat = 8'h81;
        budget = 4 * FC;
        while (!(pulse_cnt == 4 && pulse_tb) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("pulse3_timeout", 32'(pulse_cnt), 32'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;

        pat = 8'h60;
        wait_frames(1);
        pat = 8'h01;
        wait_frames(3);
        pat = 8'h00;
        wait_frames(1);

        check("latch_pulse_overlap", 32'(n_overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/input_controller.md
# input_controller

NES-style serial gamepad reader for the Tetris ASIC. Generates the controller latch and shift-clock pulses from the 50 MHz system clock and shifts in the 8 active-low button bits once per frame. It presents the four game-relevant buttons to the game logic, plus the full 8-bit snapshot and a slow-clock debug output.

## Interface
Parameters:
- HALF_PERIOD, 300, clk cycles per slow-clock half period (6 µs at 50 MHz); ≥ 4.
- FRAME_CYCLES, 500000, clk cycles between read requests (10 ms); fits 19 bits; must be ≥ 40·HALF_PERIOD.

Ports:
- clk  input  1  system clock, 50 MHz; the only clock.
- reset  input  1  synchronous, active-high.
- button_data_in  input  1  controller serial data, active-low (0 = pressed), asynchronous.
- latch_tb  output  1  controller latch, active-high.
- pulse_tb  output  1  controller shift clock, active-high.
- slow_clk_tb  output  1  free-running divided clock (debug).
- button_data_out_tb  output  4  {A, Down, Left, Right}, active-high.
- buttons  output  8  full snapshot, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- data_valid  output  1  one-clk strobe when a frame completes.

## Operation
- button_data_in passes through a 2-flop synchronizer; all sampling uses the synchronized value, inverted.
- Divider: counter 0..HALF_PERIOD-1; at terminal count a "tick" occurs and slow_clk_tb toggles.
- Frame counter: 0..FRAME_CYCLES-1, wraps; at terminal count sets a pending-read flag.
- States: IDLE, LATCH, SHIFT, DONE. Step index s counts ticks from frame start.
- IDLE → LATCH at the first tick on which slow_clk_tb rises while pending is set; pending clears; s=0.
- s0: latch_tb=1. s2: latch_tb=0. s3: sample A into shift bit 0.
- Eight pulses, k=0..7: pulse_tb=1 at s(4+2k), 0 at s(5+2k). At the falling edge of pulse k (k=0..6), sample bit k+1. Pulse 7 is trailing; nothing sampled.
- s19 → DONE: copy shift register to buttons; update button_data_out_tb; data_valid=1 for that one clk; next cycle → IDLE.
- A request arriving while not IDLE is dropped (pending is not set again).
- latch_tb and pulse_tb never both high.

## Timing
- Reset values: all outputs 0; state IDLE; all counters, pending flag and shift register 0.
- Reset mid-frame aborts the frame; the partial data is discarded and latch/pulse drop on the next edge.
- All outputs are registered. The latch high time is 2·HALF_PERIOD clk cycles. Each pulse high time is HALF_PERIOD cycles.
- A frame lasts 19 ticks from latch rise to data_valid. Outputs update on the clk edge of tick s19.
- Input-to-output latency of the synchronizer is 2 clk cycles, negligible relative to HALF_PERIOD.

## Configuration
- INPUT_CTRL_EDGE_EN defined: button_data_out_tb bits become press events. Each bit is 1 only in the data_valid cycle, and only when the button is pressed in this frame and was not pressed in the previous frame; otherwise 0. buttons stays level.
- Undefined: button_data_out_tb is a level copy of the latest frame, held until the next frame.

## Test plan
- Sim params HALF_PERIOD=4, FRAME_CYCLES=200. Reset 3 cycles → all outputs 0. First latch_tb rise at the first slow_clk_tb rise after cycle 199. latch high 8 cycles. Exactly 8 pulses, 4 cycles high each.
- Data held 1 (nothing pressed) → data_valid pulses each frame; buttons=8'h00; button_data_out_tb=4'b0000.
- Drive 0 only during the A slot and the Right slot (bits 0 and 7) → buttons=8'h81; button_data_out_tb=4'b1001.
- Drive 0 for the Down and Left slots → buttons=8'h60; button_data_out_tb=4'b0110. The value holds until the next frame.
- Assert reset during pulse 3 → latch/pulse/outputs 0 next cycle; no data_valid for that frame; the next frame reads normally.
- With INPUT_CTRL_EDGE_EN, hold A pressed for 3 frames → button_data_out_tb[3]=1 only in the first frame's data_valid cycle. buttons[0]=1 in all three frames.
